// File: rtl/conv3x3_stream_if.sv
// Pixel stream, kernel-load and result signals of the 3x3 convolution stage.
// The slave modport is the convolution block; master is whatever feeds and consumes it.
interface conv3x3_stream_if #(
    parameter int PIX_W = 21,
    parameter int W_W   = 18
);
    logic signed [PIX_W-1:0] pixel_in;
    logic [4:0]              hcount_in;
    logic [4:0]              vcount_in;
    logic                    data_valid_in;
    logic                    w_we;
    logic [3:0]              w_addr;
    logic signed [W_W-1:0]   w_data;
    logic signed [PIX_W-1:0] pixel_out;
    logic [4:0]              hcount_out;
    logic [4:0]              vcount_out;
    logic                    data_valid_out;

    modport slave (
        input  pixel_in, hcount_in, vcount_in, data_valid_in,
        input  w_we, w_addr, w_data,
        output pixel_out, hcount_out, vcount_out, data_valid_out
    );

    modport master (
        output pixel_in, hcount_in, vcount_in, data_valid_in,
        output w_we, w_addr, w_data,
        input  pixel_out, hcount_out, vcount_out, data_valid_out
    );
endinterface

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 signed convolution over raster-order pixels with two line buffers and a
// runtime-loadable kernel. Optional macro RELU_EN clamps negative results to zero.
module conv3x3_stream #(
    parameter int IMG_W = 32,
    parameter int PIX_W = 21,
    parameter int W_W   = 18,
    parameter int FRAC  = 16
) (
    input  logic            clk_in,
    input  logic            rst_in,
    conv3x3_stream_if.slave bus
);
    localparam int PROD_W = PIX_W + W_W;
    localparam int SUM_W  = PROD_W + 4;

    localparam logic signed [W_W-1:0]   W_ZERO   = {W_W{1'b0}};
    localparam logic signed [W_W-1:0]   W_ONE    = {{(W_W-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
    localparam logic signed [PIX_W-1:0] PIX_ZERO = {PIX_W{1'b0}};
    localparam logic signed [PIX_W-1:0] OUT_MAX  = {1'b0, {(PIX_W-1){1'b1}}};
    localparam logic signed [PIX_W-1:0] OUT_MIN  = {1'b1, {(PIX_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] SAT_MAX  = {{(SUM_W-PIX_W+1){1'b0}}, {(PIX_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN  = {{(SUM_W-PIX_W+1){1'b1}}, {(PIX_W-1){1'b0}}};
    localparam logic signed [PROD_W-1:0] PROD_ZERO = {PROD_W{1'b0}};
    localparam logic signed [SUM_W-1:0]  SUM_ZERO  = {SUM_W{1'b0}};

    function automatic logic signed [PROD_W-1:0] sext_pix(input logic signed [PIX_W-1:0] x);
        return {{(PROD_W-PIX_W){x[PIX_W-1]}}, x};
    endfunction

    function automatic logic signed [PROD_W-1:0] sext_w(input logic signed [W_W-1:0] x);
        return {{(PROD_W-W_W){x[W_W-1]}}, x};
    endfunction

    function automatic logic signed [SUM_W-1:0] sext_prod(input logic signed [PROD_W-1:0] x);
        return {{(SUM_W-PROD_W){x[PROD_W-1]}}, x};
    endfunction

    logic signed [W_W-1:0]    w_q [9];
    logic signed [PIX_W-1:0]  lb_top_q [IMG_W];
    logic signed [PIX_W-1:0]  lb_mid_q [IMG_W];
    logic signed [PIX_W-1:0]  win_q [9];
    logic                     frame_ok_q;
    logic                     win_vld_q;
    logic [4:0]               win_h_q;
    logic [4:0]               win_v_q;
    logic signed [PROD_W-1:0] prod_d [9];
    logic signed [PROD_W-1:0] prod_q [9];
    logic                     prod_vld_q;
    logic [4:0]               prod_h_q;
    logic [4:0]               prod_v_q;
    logic signed [SUM_W-1:0]  sum_d;
    logic signed [SUM_W-1:0]  sum_q;
    logic                     sum_vld_q;
    logic [4:0]               sum_h_q;
    logic [4:0]               sum_v_q;
    logic signed [SUM_W-1:0]  shift_s;
    logic signed [PIX_W-1:0]  res_d;
    logic signed [PIX_W-1:0]  pix_out_q;
    logic [4:0]               h_out_q;
    logic [4:0]               v_out_q;
    logic                     vld_out_q;
    logic                     acc_s;
    logic                     start_s;
    logic                     emit_s;

    assign acc_s   = bus.data_valid_in;
    assign start_s = acc_s && (bus.hcount_in == 5'd0) && (bus.vcount_in == 5'd0);
    // Outputs are only trusted once a frame start has refilled the line buffers after reset.
    assign emit_s  = acc_s && (frame_ok_q || start_s) &&
                     (bus.hcount_in >= 5'd2) && (bus.vcount_in >= 5'd2);

    // Kernel weight registers; identity kernel out of reset, out-of-range addresses ignored.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < 9; i++) begin
                w_q[i] <= (i == 4) ? W_ONE : W_ZERO;
            end
        end else begin
            for (int i = 0; i < 9; i++) begin
                if (bus.w_we && (bus.w_addr == 4'(i))) begin
                    w_q[i] <= bus.w_data;
                end
            end
        end
    end

    // Two line memories holding rows v-2 (top) and v-1 (mid), indexed by column.
    always_ff @(posedge clk_in) begin
        if (acc_s) begin
            lb_top_q[bus.hcount_in] <= lb_mid_q[bus.hcount_in];
            lb_mid_q[bus.hcount_in] <= bus.pixel_in;
        end
    end

    // 3x3 window shifting left on each accepted pixel; column 2 is the newest column.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= PIX_ZERO;
            end
            frame_ok_q <= 1'b0;
            win_vld_q  <= 1'b0;
            win_h_q    <= 5'd0;
            win_v_q    <= 5'd0;
        end else begin
            win_vld_q <= emit_s;
            if (start_s) begin
                frame_ok_q <= 1'b1;
            end
            if (acc_s) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r*3]     <= win_q[r*3 + 1];
                    win_q[r*3 + 1] <= win_q[r*3 + 2];
                end
                win_q[2] <= lb_top_q[bus.hcount_in];
                win_q[5] <= lb_mid_q[bus.hcount_in];
                win_q[8] <= bus.pixel_in;
                win_h_q  <= bus.hcount_in - 5'd1;
                win_v_q  <= bus.vcount_in - 5'd1;
            end
        end
    end

    // Stage 1 products, formed with whatever weights are current this cycle.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            prod_d[i] = sext_pix(win_q[i]) * sext_w(w_q[i]);
        end
    end

    // Stage 1 register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < 9; i++) begin
                prod_q[i] <= PROD_ZERO;
            end
            prod_vld_q <= 1'b0;
            prod_h_q   <= 5'd0;
            prod_v_q   <= 5'd0;
        end else begin
            prod_q     <= prod_d;
            prod_vld_q <= win_vld_q;
            prod_h_q   <= win_h_q;
            prod_v_q   <= win_v_q;
        end
    end

    // Stage 2 adder tree input: sum of the nine sign-extended products.
    always_comb begin
        sum_d = SUM_ZERO;
        for (int i = 0; i < 9; i++) begin
            sum_d = sum_d + sext_prod(prod_q[i]);
        end
    end

    // Stage 2 register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sum_q     <= SUM_ZERO;
            sum_vld_q <= 1'b0;
            sum_h_q   <= 5'd0;
            sum_v_q   <= 5'd0;
        end else begin
            sum_q     <= sum_d;
            sum_vld_q <= prod_vld_q;
            sum_h_q   <= prod_h_q;
            sum_v_q   <= prod_v_q;
        end
    end

    // Stage 3: floor rescale by the weight fraction, then saturate to the pixel range.
    always_comb begin
        shift_s = sum_q >>> FRAC;
        if (shift_s > SAT_MAX) begin
            res_d = OUT_MAX;
        end else if (shift_s < SAT_MIN) begin
            res_d = OUT_MIN;
        end else begin
            res_d = shift_s[PIX_W-1:0];
        end
`ifdef RELU_EN
        if (res_d[PIX_W-1]) begin
            res_d = PIX_ZERO;
        end else begin
            res_d = res_d;
        end
`endif
    end

    // Registered result and centre coordinates.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pix_out_q <= PIX_ZERO;
            h_out_q   <= 5'd0;
            v_out_q   <= 5'd0;
            vld_out_q <= 1'b0;
        end else begin
            pix_out_q <= res_d;
            h_out_q   <= sum_h_q;
            v_out_q   <= sum_v_q;
            vld_out_q <= sum_vld_q;
        end
    end

    assign bus.pixel_out      = pix_out_q;
    assign bus.hcount_out     = h_out_q;
    assign bus.vcount_out     = v_out_q;
    assign bus.data_valid_out = vld_out_q;
endmodule

// File: tb/tb_conv3x3_stream.sv
// Self-checking bench for conv3x3_stream: table of kernel/pattern/gap frames, randomized
// frames against an arithmetic window model, mid-frame kernel write and mid-frame reset.
`timescale 1ns/1ps
module tb_conv3x3_stream;
    localparam int PIX_W = 21;
    localparam int W_W   = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;

    conv3x3_stream_if #(.PIX_W(PIX_W), .W_W(W_W)) bus ();

    conv3x3_stream #(.IMG_W(32), .PIX_W(PIX_W), .W_W(W_W), .FRAC(16)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     h;
        int     v;
        longint val;
        int     acc;
    } exp_t;

    typedef struct {
        int kmode;
        int pmode;
        int gmode;
        bit use_const;
        int cval;
    } vec_t;

    exp_t   q[$];
    vec_t   vecs[8];
    longint kern[9];
    int     img[32][32];
    int     n_chk = 0;
    int     n_fail = 0;
    int     frame_outs = 0;
    bit     stream_ok = 1'b0;
    bit     const_en = 1'b0;
    longint cur_const = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: direct 3x3 dot product over the frame image, floor shift, saturation.
    function automatic longint model(input int h, input int v);
        longint s = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                s += longint'(img[v-2+r][h-2+c]) * kern[r*3+c];
        s = s >>> 16;
        if (s > 64'sd1048575) s = 64'sd1048575;
        else if (s < -64'sd1048576) s = -64'sd1048576;
`ifdef RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    // Output monitor: every result must match the head of the expectation queue.
    always @(negedge clk) begin
        if (bus.data_valid_out === 1'b1) begin
            frame_outs++;
            if (q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("hcount_out", longint'(bus.hcount_out), longint'(e.h));
                check("vcount_out", longint'(bus.vcount_out), longint'(e.v));
                check("pixel_out", longint'($signed(bus.pixel_out)), e.val);
                check("latency", longint'(cyc - e.acc), 64'sd3);
                if (const_en) check("uniform_value", longint'($signed(bus.pixel_out)), cur_const);
            end
        end
    end

    task automatic write_w(input int addr, input int val);
        @(posedge clk); #1;
        bus.data_valid_in = 1'b0;
        bus.w_we   = 1'b1;
        bus.w_addr = 4'(addr);
        bus.w_data = val[W_W-1:0];
        if (addr <= 8) kern[addr] = longint'(val);
        @(posedge clk); #1;
        bus.w_we = 1'b0;
    endtask

    task automatic load_kernel(input int mode);
        for (int i = 0; i < 9; i++) begin
            int val;
            case (mode)
                0: val = (i == 4) ? 65536 : 0;
                1: val = 7282;
                2: val = 65536;
                3: val = -65536;
                4: val = (i == 4) ? -65536 : 0;
                default: val = int'($urandom_range(0, 262143)) - 131072;
            endcase
            write_w(i, val);
        end
        for (int a = 9; a < 16; a++) write_w(a, int'($urandom_range(0, 262143)) - 131072);
    endtask

    task automatic drive_pix(input int h, input int v, input int val, input int gap);
        @(posedge clk); #1;
        img[v][h] = val;
        if (h == 0 && v == 0) stream_ok = 1'b1;
        bus.data_valid_in = 1'b1;
        bus.pixel_in  = val[PIX_W-1:0];
        bus.hcount_in = 5'(h);
        bus.vcount_in = 5'(v);
        if (stream_ok && h >= 2 && v >= 2) q.push_back('{h-1, v-1, model(h, v), cyc + 1});
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            bus.data_valid_in = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.data_valid_in = 1'b0;
        end
    endtask

    task automatic run_frame(input int pmode, input int gmode, input bit use_c, input int cval,
                             input int wr_row, input int rst_row);
        frame_outs = 0;
        const_en   = use_c;
        cur_const  = longint'(cval);
        for (int v = 0; v < 32; v++) begin
            for (int h = 0; h < 32; h++) begin
                int val;
                int gap;
                if (v == wr_row && h == 0) load_kernel(1);
                if (v == rst_row && h == 0) begin
                    @(posedge clk); #1;
                    rst = 1'b1;
                    bus.data_valid_in = 1'b0;
                    q.delete();
                    stream_ok = 1'b0;
                    #1;
                    check("rst_valid_low", longint'(bus.data_valid_out), 0);
                    check("rst_pixel_zero", longint'($signed(bus.pixel_out)), 0);
                    repeat (2) @(posedge clk);
                    #1;
                    rst = 1'b0;
                    for (int i = 0; i < 9; i++) kern[i] = (i == 4) ? 65536 : 0;
                    frame_outs = 0;
                end
                case (pmode)
                    0: val = 644573;
                    1: val = ((h + v) % 2 == 0) ? 644573 : -26653;
                    default: val = int'($urandom_range(0, 2097151)) - 1048576;
                endcase
                case (gmode)
                    0: gap = 0;
                    1: gap = 1;
                    default: gap = int'($urandom_range(0, 2));
                endcase
                drive_pix(h, v, val, gap);
            end
        end
        idle(10);
        if (rst_row >= 0) check("no_output_before_frame_start", longint'(frame_outs), 0);
        else check("frame_result_count", longint'(frame_outs), 900);
        check("queue_drained", longint'(q.size()), 0);
        const_en = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{0, 0, 0, 1'b1, 644573};
        vecs[1] = '{1, 0, 0, 1'b1, 644592};
        vecs[2] = '{2, 0, 0, 1'b1, 1048575};
`ifdef RELU_EN
        vecs[3] = '{3, 0, 0, 1'b1, 0};
`else
        vecs[3] = '{3, 0, 0, 1'b1, -1048576};
`endif
        vecs[4] = '{4, 1, 0, 1'b0, 0};
        vecs[5] = '{0, 0, 1, 1'b1, 644573};
        vecs[6] = '{5, 2, 2, 1'b0, 0};
        vecs[7] = '{5, 2, 0, 1'b0, 0};
        for (int i = 0; i < 9; i++) kern[i] = (i == 4) ? 65536 : 0;

        bus.pixel_in = '0;
        bus.hcount_in = 5'd0;
        bus.vcount_in = 5'd0;
        bus.data_valid_in = 1'b0;
        bus.w_we = 1'b0;
        bus.w_addr = 4'd0;
        bus.w_data = '0;
        rst = 1'b1;
        #2;
        check("reset_valid", longint'(bus.data_valid_out), 0);
        check("reset_pixel", longint'($signed(bus.pixel_out)), 0);
        check("reset_hcount", longint'(bus.hcount_out), 0);
        check("reset_vcount", longint'(bus.vcount_out), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // First frame runs on the reset-default identity kernel without any writes.
        run_frame(vecs[0].pmode, vecs[0].gmode, vecs[0].use_const, vecs[0].cval, -1, -1);
        for (int i = 1; i < 8; i++) begin
            load_kernel(vecs[i].kmode);
            run_frame(vecs[i].pmode, vecs[i].gmode, vecs[i].use_const, vecs[i].cval, -1, -1);
        end

        load_kernel(0);
        run_frame(2, 0, 1'b0, 0, 16, -1);

        load_kernel(1);
        run_frame(2, 0, 1'b0, 0, -1, 15);
        run_frame(2, 2, 1'b0, 0, -1, -1);
        run_frame(0, 0, 1'b1, 644573, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
